cla_nibble_sequencer: RTL and testbench



---
 rtl/cla_pkg.sv | 17 +
 rtl/generic_cla.sv | 55 +++++
 rtl/cla_nibble_sequencer.sv | 141 ++++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types for the nibble-serial CLA sequencer: FSM state encoding and counter sizing.
// Latency: none (types and a constant function only).
// Backpressure: not applicable.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble counter width: ceil(log2(nib)), but never narrower than one bit.
    function automatic int NIB_BITS(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/generic_cla.sv
// 4-bit carry-lookahead adder slice built from propagate/generate, carry and sum children.
// Latency: purely combinational.
// Backpressure: none; the slice evaluates its inputs continuously.
module cla_pg (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o,
    output logic [3:0] g_o
);
    assign p_o = a_i ^ b_i;
    assign g_o = a_i & b_i;
endmodule

module cla_carry (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       c_i,
    output logic [4:0] c_o
);
    // Every carry is expanded directly from p/g and the slice carry-in, no rippling.
    assign c_o[0] = c_i;
    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign c_o[4] = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                  | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);
endmodule

module cla_sum (
    input  logic [3:0] p_i,
    input  logic [3:0] c_i,
    output logic [3:0] s_o
);
    assign s_o = p_i ^ c_i;
endmodule

module generic_cla (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    cla_pg    u_pg    (.a_i(a_i), .b_i(b_i), .p_o(p), .g_o(g));
    cla_carry u_carry (.p_i(p), .g_i(g), .c_i(cin_i), .c_o(c));
    cla_sum   u_sum   (.p_i(p), .c_i(c[3:0]), .s_o(sum_o));

    assign cout_o = c[4];
endmodule

// File: rtl/cla_nibble_sequencer.sv
// WIDTH-bit add/subtract by running one 4-bit CLA slice over the operands, LSB nibble first.
// Latency: NIB+1 edges from accept to done; one result per NIB+1 cycles back-to-back.
// Backpressure: start is only honoured in IDLE/DONE; a start during RUN is dropped, not queued.
module cla_nibble_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = NIB_BITS(NIB);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_c;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign last   = (state_q == RUN) && (cnt_q == CW'(NIB - 1));

    // Pick the operand nibbles addressed by the counter.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    generic_cla u_cla (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .sum_o  (nib_s),
        .cout_o (nib_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: DONE lasts one cycle, either re-entering RUN or dropping to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next-state: latch on accept, then one nibble per RUN cycle.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < NIB; i++) begin
                if (cnt_q == CW'(i)) sum_d[4*i +: 4] = nib_s;
            end
            carry_d = nib_c;
            if (last) begin
                // Counter parks on the last nibble; the exit to DONE stops it.
                cout_d = nib_c;
                ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers; reset throws away any partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for the nibble-serial CLA sequencer at WIDTH=16 and WIDTH=4.
// Latency: expected NIB edges from accept edge until done is seen.
// Backpressure: exercises start during RUN and start held through DONE.
module tb_cla_nibble_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start4;
    logic        sub4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    int n_chk;
    int n_fail;

    cla_nibble_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_nibble_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Steps the clock until done is seen (bounded), counting edges and busy cycles.
    task automatic wait_done16(output int ticks, output int busy_cnt);
        ticks    = 0;
        busy_cnt = 0;
        while (!done && ticks < 20) begin
            if (busy) busy_cnt++;
            tick();
            ticks++;
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic vsub,
                         input logic [15:0] esum, input logic ecout, input logic eovf);
        int t;
        int bc;
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        wait_done16(t, bc);
        chk({tag, "_lat"},  t,    4);
        chk({tag, "_busy"}, bc,   4);
        chk({tag, "_sum"},  sum,  esum);
        chk({tag, "_cout"}, cout, ecout);
        chk({tag, "_ovf"},  ovf,  eovf);
        tick();
        chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int t;
        int bc;
        int seen;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_outputs", {busy, done, sum, cout, ovf}, 20'h0);
        chk("rst_outputs4", {busy4, done4, sum4, cout4, ovf4}, 8'h0);

        run16("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run16("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run16("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run16("sub_ovf_cin", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Reset on the second RUN cycle; cout/ovf are both 1 from the previous op.
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_outputs", {busy, done, sum, cout, ovf}, 20'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("midrst_no_done", seen, 0);
        run16("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // A start during RUN with other operands must not disturb the result.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 16'hFFFF; b = 16'h0001; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done16(t, bc);
        chk("midstart_lat", t, 1);
        chk("midstart_sum", sum, 16'h3333);
        tick();
        chk("midstart_idle", {busy, done}, 2'b00);

        // Back-to-back: start held high across the done cycle.
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        wait_done16(t, bc);
        chk("b2b_first_lat", t, 4);
        chk("b2b_first_sum", sum, 16'h0003);
        a = 16'h1000; b = 16'h0100;
        tick();
        start = 1'b0;
        chk("b2b_accept_busy", {busy, done}, 2'b10);
        wait_done16(t, bc);
        chk("b2b_second_gap", t + 1, 5);
        chk("b2b_second_sum", sum, 16'h1100);
        tick();

        // WIDTH=4: single RUN cycle.
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("w4_busy", {busy4, done4}, 2'b10);
        tick();
        chk("w4_done", {busy4, done4}, 2'b01);
        chk("w4_result", {sum4, cout4, ovf4}, 6'b0001_1_1);
        tick();
        chk("w4_idle", {busy4, done4}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
